// File: rtl/eth_payload_tx.sv
// Single-frame payload buffer for the Ethernet transmit path: collects bytes, pulses
// frame_start, streams MSB-first N-bit chunks zero-padded to MIN_LEN, then holds an IFG.
module eth_payload_tx #(
  parameter int N          = 2,
  parameter int MIN_LEN    = 46,
  parameter int MAX_LEN    = 1500,
  parameter int IFG_CYCLES = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic         frame_start,
  output logic [10:0]  frame_len,
  input  logic         payload_req,
  output logic         axiov,
  output logic [N-1:0] axiod,
  output logic         busy
);

  localparam logic [2:0] S_FILL     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_WAIT_REQ = 3'd2;
  localparam logic [2:0] S_STREAM   = 3'd3;
  localparam logic [2:0] S_GAP      = 3'd4;

  localparam int                CHUNKS     = 8 / N;
  localparam logic [1:0]        CHUNK_LAST = 2'(CHUNKS - 1);
  localparam int                GAP_W      = $clog2(IFG_CYCLES + 1);
  localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(IFG_CYCLES);
  localparam logic [10:0]       MIN_LEN_W  = 11'(MIN_LEN);
  localparam logic [10:0]       MAX_LEN_W  = 11'(MAX_LEN);
  localparam logic [10:0]       LAST_PTR   = 11'(MAX_LEN - 1);

  logic [7:0]       mem [MAX_LEN];
  logic [7:0]       rd_data_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       byte_val;
  logic [10:0]      wr_ptr_reg;
  logic [10:0]      byte_cnt_reg;
  logic [10:0]      frame_len_reg;
  logic [10:0]      rd_addr;
  logic [10:0]      wr_len_next;
  logic [1:0]       chunk_cnt_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic [2:0]       state_reg;
  logic [2:0]       state_next;
  logic             in_ready_reg;
  logic             frame_start_reg;
  logic             axiov_reg;
  logic             busy_reg;
  logic [N-1:0]     axiod_reg;
  logic             accept;
  logic             byte_last;
  logic             step;
  logic             stream_end;
  logic             gap_end;

  always_comb begin
    accept      = (state_reg == S_FILL) && in_valid && in_ready_reg;
    // The MAX_LEN-th byte closes the frame even without in_last.
    byte_last   = accept && (in_last || (wr_ptr_reg == LAST_PTR));
    wr_len_next = wr_ptr_reg + 11'd1;
    // The WAIT_REQ cycle that sees payload_req already emits chunk 0, so the stream has no bubble.
    step        = (state_reg == S_STREAM) || ((state_reg == S_WAIT_REQ) && payload_req);
    stream_end  = step && (chunk_cnt_reg == CHUNK_LAST) &&
                  (byte_cnt_reg == frame_len_reg - 11'd1);
    gap_end     = (state_reg == S_GAP) && (gap_cnt_reg == GAP_LAST);
    // While streaming, keep the next byte in flight; before that, park on address 0.
    rd_addr     = (state_reg == S_STREAM) ? byte_cnt_reg + 11'd1 : 11'd0;
    byte_val    = (byte_cnt_reg < wr_ptr_reg) ? rd_data_reg : 8'h00;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FILL:     if (byte_last) state_next = S_START;
      S_START:    state_next = S_WAIT_REQ;
      S_WAIT_REQ: begin
        if (stream_end)
          state_next = S_GAP;
        else if (step)
          state_next = S_STREAM;
      end
      S_STREAM:   if (stream_end) state_next = S_GAP;
      S_GAP:      if (gap_end) state_next = S_FILL;
      default:    state_next = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr_reg] <= in_data;
    if (rd_addr < MAX_LEN_W)
      rd_data_reg <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_FILL;
      wr_ptr_reg      <= 11'd0;
      byte_cnt_reg    <= 11'd0;
      chunk_cnt_reg   <= 2'd0;
      gap_cnt_reg     <= '0;
      frame_len_reg   <= 11'd0;
      frame_start_reg <= 1'b0;
      axiov_reg       <= 1'b0;
      axiod_reg       <= '0;
      shift_reg       <= 8'h00;
      in_ready_reg    <= 1'b1;
      busy_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      in_ready_reg    <= (state_next == S_FILL);
      busy_reg        <= (state_next != S_FILL);
      frame_start_reg <= byte_last;

      if (accept)
        wr_ptr_reg <= wr_len_next;
      if (byte_last)
        frame_len_reg <= (wr_len_next > MIN_LEN_W) ? wr_len_next : MIN_LEN_W;

      if (step) begin
        axiov_reg <= 1'b1;
        if (chunk_cnt_reg == 2'd0) begin
          axiod_reg <= byte_val[7 -: N];
          shift_reg <= byte_val << N;
        end else begin
          axiod_reg <= shift_reg[7 -: N];
          shift_reg <= shift_reg << N;
        end
        if (chunk_cnt_reg == CHUNK_LAST) begin
          chunk_cnt_reg <= 2'd0;
          byte_cnt_reg  <= byte_cnt_reg + 11'd1;
        end else begin
          chunk_cnt_reg <= chunk_cnt_reg + 2'd1;
        end
      end else begin
        axiov_reg <= 1'b0;
        axiod_reg <= '0;
      end

      if (state_reg == S_GAP)
        gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
      if (gap_end) begin
        gap_cnt_reg   <= '0;
        wr_ptr_reg    <= 11'd0;
        byte_cnt_reg  <= 11'd0;
        chunk_cnt_reg <= 2'd0;
      end
    end
  end

  assign in_ready    = in_ready_reg;
  assign frame_start = frame_start_reg;
  assign frame_len   = frame_len_reg;
  assign axiov       = axiov_reg;
  assign axiod       = axiod_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_eth_payload_tx.sv
// Scoreboard bench for eth_payload_tx: one N=2 and one N=4 instance, selected by sel.
module tb_eth_payload_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       payload_req = 1'b0;
  logic       sel = 1'b0;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  logic [7:0] tx_bytes[$];
  logic [3:0] exp_q[$];

  logic        in_valid2, in_valid4, payload_req2, payload_req4;
  logic        in_ready2, in_ready4, frame_start2, frame_start4;
  logic [10:0] frame_len2, frame_len4;
  logic        axiov2, axiov4, busy2, busy4;
  logic [1:0]  axiod2;
  logic [3:0]  axiod4;
  logic        obs_in_ready, obs_frame_start, obs_axiov, obs_busy;
  logic [10:0] obs_frame_len;
  logic [3:0]  obs_axiod;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign in_valid2       = in_valid & ~sel;
  assign in_valid4       = in_valid & sel;
  assign payload_req2    = payload_req & ~sel;
  assign payload_req4    = payload_req & sel;
  assign obs_in_ready    = sel ? in_ready4 : in_ready2;
  assign obs_frame_start = sel ? frame_start4 : frame_start2;
  assign obs_frame_len   = sel ? frame_len4 : frame_len2;
  assign obs_axiov       = sel ? axiov4 : axiov2;
  assign obs_axiod       = sel ? axiod4 : {2'b00, axiod2};
  assign obs_busy        = sel ? busy4 : busy2;

  eth_payload_tx #(.N(2), .MIN_LEN(46), .MAX_LEN(1500), .IFG_CYCLES(48)) u_dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid2), .in_last(in_last),
    .in_ready(in_ready2), .frame_start(frame_start2), .frame_len(frame_len2),
    .payload_req(payload_req2), .axiov(axiov2), .axiod(axiod2), .busy(busy2)
  );

  eth_payload_tx #(.N(4), .MIN_LEN(46), .MAX_LEN(1500), .IFG_CYCLES(48)) u_dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid4), .in_last(in_last),
    .in_ready(in_ready4), .frame_start(frame_start4), .frame_len(frame_len4),
    .payload_req(payload_req4), .axiov(axiov4), .axiod(axiod4), .busy(busy4)
  );

  // Expected chunk stream for tx_bytes, padded with zero bytes to 46.
  task automatic push_expected();
    int nbits;
    int nb;
    int flen;
    int b;
    nbits = sel ? 4 : 2;
    nb    = tx_bytes.size();
    flen  = (nb < 46) ? 46 : nb;
    for (int k = 0; k < flen; k++) begin
      b = (k < nb) ? int'(tx_bytes[k]) : 0;
      for (int c = 0; c < 8 / nbits; c++)
        exp_q.push_back(4'((b >> (8 - nbits * (c + 1))) & ((1 << nbits) - 1)));
    end
  endtask

  task automatic send_bytes(input bit with_last, input bit hold_next);
    int t;
    for (int i = 0; i < tx_bytes.size(); i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = tx_bytes[i];
      in_last  = with_last && (i == tx_bytes.size() - 1);
      t = 0;
      forever begin
        @(negedge clk);
        if (obs_in_ready === 1'b1) break;
        t++;
        if (t > 300) begin
          n_tests++; n_fail++;
          $display("FAIL send_timeout: byte %0d never accepted, in_ready=%b required 1", i, obs_in_ready);
          break;
        end
      end
    end
    @(posedge clk);
    #1;
    if (hold_next) begin
      in_valid = 1'b1;
      in_data  = 8'h77;
      in_last  = 1'b1;
    end else begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_frame_start(output int fs_cyc);
    int t;
    t = 0;
    fs_cyc = -1;
    while (fs_cyc < 0) begin
      @(negedge clk);
      if (obs_frame_start === 1'b1) fs_cyc = cyc;
      else begin
        t++;
        if (t > 300) begin
          n_tests++; n_fail++;
          $display("FAIL frame_start_timeout: frame_start=%b required 1 within 300 cycles", obs_frame_start);
          fs_cyc = cyc;
        end
      end
    end
  endtask

  // Called on the frame_start cycle; drains the scoreboard against the stream.
  task automatic run_stream(input int req_delay, input int exp_len, input bit toggle,
                            output int fall_cyc, output logic [3:0] last_chunk);
    int nvalid;
    int waitc;
    int nbits;
    bit done;
    logic [3:0] exp;
    nbits = sel ? 4 : 2;
    n_tests++;
    if (obs_frame_len !== 11'(exp_len) || obs_axiov !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_len: got len=%0d axiov=%b required len=%0d axiov=0", obs_frame_len, obs_axiov, exp_len);
    end
    if (req_delay >= 0) begin
      for (int i = 0; i < req_delay; i++) begin
        @(negedge clk);
        n_tests++;
        if (obs_axiov !== 1'b0 || obs_frame_start !== 1'b0) begin
          n_fail++;
          $display("FAIL pre_req_idle: got axiov=%b frame_start=%b required 0/0", obs_axiov, obs_frame_start);
        end
      end
      @(posedge clk);
      #1 payload_req = 1'b1;
    end
    nvalid = 0; waitc = 0; done = 0; last_chunk = 4'h0;
    while (!done) begin
      @(negedge clk);
      if (obs_axiov === 1'b1) begin
        nvalid++;
        last_chunk = obs_axiod;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL chunk_extra: got chunk %0h at index %0d, required none", obs_axiod, nvalid - 1);
        end else begin
          exp = exp_q.pop_front();
          if (obs_axiod !== exp) begin
            n_fail++;
            $display("FAIL chunk_data: index %0d got %0h required %0h", nvalid - 1, obs_axiod, exp);
          end
        end
        n_tests++;
        if (obs_in_ready !== 1'b0 || obs_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_flags: got in_ready=%b busy=%b required 0/1", obs_in_ready, obs_busy);
        end
        if (toggle) begin
          in_valid = ~in_valid;
          in_data  = 8'h99;
          in_last  = 1'b1;
        end
        if (nvalid > 8000) done = 1;
      end else if (nvalid > 0) begin
        done = 1;
      end else begin
        waitc++;
        if (waitc > 3) begin
          n_tests++; n_fail++;
          $display("FAIL stream_start_timeout: axiov=%b required 1 within 3 cycles of request", obs_axiov);
          done = 1;
        end
      end
    end
    fall_cyc = cyc;
    payload_req = 1'b0;
    if (toggle) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    n_tests++;
    if (nvalid != exp_len * 8 / nbits) begin
      n_fail++;
      $display("FAIL stream_len: got %0d valid cycles required %0d", nvalid, exp_len * 8 / nbits);
    end
    n_tests++;
    if (exp_q.size() != 0 || obs_axiod !== 4'h0) begin
      n_fail++;
      $display("FAIL stream_tail: got %0d chunks left, axiod=%0h after fall, required 0/0", exp_q.size(), obs_axiod);
    end
    exp_q.delete();
  endtask

  task automatic check_idle(input string name);
    n_tests++;
    if (obs_axiov !== 1'b0 || obs_axiod !== 4'h0 || obs_frame_start !== 1'b0 ||
        obs_busy !== 1'b0 || obs_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: got axiov=%b axiod=%0h fs=%b busy=%b in_ready=%b required 0/0/0/0/1",
               name, obs_axiov, obs_axiod, obs_frame_start, obs_busy, obs_in_ready);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check_idle(s == 0 ? "reset_n2" : "reset_n4");
      n_tests++;
      if (obs_frame_len !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_frame_len: got %0d required 0", obs_frame_len);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_short_frame();
    int fs, fall;
    logic [3:0] lc;
    sel = 1'b0;
    tx_bytes = '{8'hEB, 8'h01, 8'h02, 8'h03};
    push_expected();
    send_bytes(1'b1, 1'b0);
    wait_frame_start(fs);
    run_stream(10, 46, 1'b0, fall, lc);
    $display("[TB] short frame N=2 done at cycle %0d", fall);
  endtask

  task automatic test_back_to_back();
    int fs, fall, fall2;
    logic [3:0] lc;
    sel = 1'b0;
    tx_bytes.delete();
    for (int i = 0; i < 60; i++) tx_bytes.push_back(8'(i));
    push_expected();
    send_bytes(1'b1, 1'b0);
    wait_frame_start(fs);
    run_stream(3, 60, 1'b0, fall, lc);
    n_tests++;
    if (lc !== 4'h3) begin
      n_fail++;
      $display("FAIL last_dibit: got %0h required 3", lc);
    end
    tx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    push_expected();
    send_bytes(1'b1, 1'b0);
    wait_frame_start(fs);
    n_tests++;
    if (fs - fall < 49) begin
      n_fail++;
      $display("FAIL ifg_spacing: got %0d cycles axiov-fall to frame_start required >= 49", fs - fall);
    end
    run_stream(2, 46, 1'b0, fall2, lc);
    $display("[TB] back-to-back frames, gap %0d cycles", fs - fall);
  endtask

  task automatic test_n4();
    int fs, fall;
    logic [3:0] lc;
    sel = 1'b1;
    tx_bytes = '{8'hA5};
    push_expected();
    send_bytes(1'b1, 1'b0);
    wait_frame_start(fs);
    run_stream(4, 46, 1'b0, fall, lc);
    sel = 1'b0;
    $display("[TB] single byte N=4 done at cycle %0d", fall);
  endtask

  task automatic test_max_len();
    int fs, fall, t;
    logic [3:0] lc;
    sel = 1'b0;
    tx_bytes.delete();
    for (int i = 0; i < 1500; i++) tx_bytes.push_back(8'((i * 7 + 3) & 8'hFF));
    push_expected();
    send_bytes(1'b0, 1'b1);
    wait_frame_start(fs);
    n_tests++;
    if (obs_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL max_len_ready: got in_ready=%b required 0 after 1500th byte", obs_in_ready);
    end
    run_stream(5, 1500, 1'b0, fall, lc);
    t = 0;
    while (obs_in_ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_last = 1'b0;
    tx_bytes = '{8'h77};
    push_expected();
    wait_frame_start(fs);
    n_tests++;
    if (fs - fall < 49) begin
      n_fail++;
      $display("FAIL max_len_gap: got %0d cycles axiov-fall to frame_start required >= 49", fs - fall);
    end
    run_stream(3, 46, 1'b0, fall, lc);
    $display("[TB] 1500-byte frame plus held byte done at cycle %0d", fall);
  endtask

  task automatic test_reset_mid_stream();
    int fs, fall, nv, t;
    logic [3:0] lc, exp;
    sel = 1'b0;
    tx_bytes = '{8'h10, 8'h20, 8'h30, 8'h40};
    push_expected();
    send_bytes(1'b1, 1'b0);
    wait_frame_start(fs);
    @(posedge clk);
    #1 payload_req = 1'b1;
    nv = 0; t = 0;
    while (nv < 50 && t < 60) begin
      @(negedge clk);
      t++;
      if (obs_axiov === 1'b1) begin
        nv++;
        exp = exp_q.pop_front();
        n_tests++;
        if (obs_axiod !== exp) begin
          n_fail++;
          $display("FAIL pre_rst_chunk: index %0d got %0h required %0h", nv - 1, obs_axiod, exp);
        end
      end
    end
    n_tests++;
    if (nv != 50) begin
      n_fail++;
      $display("FAIL pre_rst_count: got %0d valid cycles required 50", nv);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    payload_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle("rst_mid_stream");
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    tx_bytes = '{8'hC3, 8'h5A, 8'hFF, 8'h81};
    push_expected();
    send_bytes(1'b1, 1'b0);
    wait_frame_start(fs);
    run_stream(4, 46, 1'b0, fall, lc);
    $display("[TB] reset mid-stream then fresh frame done at cycle %0d", fall);
  endtask

  task automatic test_req_early_and_stray_valid();
    int fs, fall;
    logic [3:0] lc;
    sel = 1'b0;
    @(posedge clk);
    #1 payload_req = 1'b1;
    tx_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    push_expected();
    send_bytes(1'b1, 1'b0);
    wait_frame_start(fs);
    run_stream(-1, 46, 1'b1, fall, lc);
    tx_bytes = '{8'h12, 8'h34};
    push_expected();
    send_bytes(1'b1, 1'b0);
    wait_frame_start(fs);
    run_stream(1, 46, 1'b0, fall, lc);
    $display("[TB] early payload_req with stray in_valid done at cycle %0d", fall);
  endtask

  initial begin
    test_reset();
    test_short_frame();
    test_back_to_back();
    test_n4();
    test_max_len();
    test_reset_mid_stream();
    test_req_early_and_stray_valid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/eth_payload_tx.md
Name: eth_payload_tx

Overview:
Payload source that sits directly upstream of the Ethernet transmit path. It buffers one outgoing frame payload, delivered as bytes, and issues a start pulse to the transmitter. When the transmitter requests payload after its header, the block streams the bytes out as contiguous N-bit chunks, zero-padded to the Ethernet minimum payload length. It then enforces an inter-frame gap before the next frame may start.

Parameters:
N, 2, output chunk width in bits; legal values 2 or 4; matches the transmitter's N.
MIN_LEN, 46, minimum payload bytes; shorter frames are zero-padded up to this.
MAX_LEN, 1500, maximum payload bytes held in the buffer.
IFG_CYCLES, 48, idle cycles after the last chunk before the next frame_start may assert.

Ports:
clk  input  1  system clock (25 or 50 MHz).
rst  input  1  synchronous, active-high reset.
in_data  input  8  payload byte.
in_valid  input  1  in_data is valid.
in_last  input  1  marks the final byte of the frame; qualified by in_valid.
in_ready  output  1  block accepts a byte this cycle.
frame_start  output  1  one-cycle pulse; frame committed, transmitter may begin its header.
frame_len  output  11  committed payload length after padding; stable from frame_start until streaming ends.
payload_req  input  1  level from transmitter: header done, payload wanted.
axiov  output  1  axiod valid.
axiod  output  N  payload chunk; MSB-first within each byte.
busy  output  1  high in every state except FILL.

Behaviour:
- Only one clock; reset is synchronous and active-high. On a cycle with rst high:
  - state goes to FILL; write pointer, read pointer and counters clear;
  - axiov=0, axiod=0, frame_start=0, frame_len=0, busy=0, in_ready=1 (registered, visible the cycle after rst).
  - Reset mid-stream discards the frame immediately, with no padding and no gap.
- Buffer: MAX_LEN x 8 memory with synchronous read; one frame at a time.
- FILL:
  - in_ready=1. A byte is accepted when in_valid && in_ready; it is written at wr_ptr and wr_ptr increments.
  - Accepting a byte with in_last=1, or the MAX_LEN-th byte (forced last; later bytes wait for the next frame), transitions to START.
  - in_ready drops the cycle after the final byte is accepted.
- START:
  - frame_start=1 for exactly one cycle.
  - frame_len = max(wr_ptr, MIN_LEN), registered.
  - Next state is WAIT_REQ.
- WAIT_REQ:
  - Waits for payload_req=1 and issues the read of address 0.
  - payload_req is ignored in every other state.
- STREAM:
  - axiov rises 1 cycle after payload_req is sampled high and stays high with no gaps for exactly frame_len*8/N cycles.
  - Byte k (k < wr_ptr) comes from memory; bytes wr_ptr .. frame_len-1 are 0x00.
  - The chunk counter walks bit index 7..0 in steps of N; axiod = byte[idx -: N]. The next byte is prefetched so that byte boundaries do not stall.
  - After the last chunk, axiov=0 and axiod=0 on the next cycle, and the state goes to GAP.
- GAP:
  - Counts IFG_CYCLES cycles, then returns to FILL with pointers cleared and in_ready=1.
- Width rules:
  - Pointers and lengths are 11 bits.
  - Chunk counter: 8/N values, wraps to 0 at the end of each byte.
  - The byte counter compares against frame_len-1 to detect the end.
- Simultaneous events:
  - in_valid outside FILL has no effect; no bytes are lost, because the upstream producer holds them while in_ready=0.
  - payload_req may stay high across the whole stream; it is not re-sampled.

Test Plan:
1. N=2; bytes EB,01,02,03 with last on 03; payload_req 10 cycles after frame_start -> frame_len=46; axiov high for 184 cycles; first dibits 11,10,10,11 then 00,00,00,01; dibits from byte 4 onward are 00.
2. N=2; 60 bytes 0x00..0x3B -> frame_len=60, no padding, 240 valid cycles, last dibit 11 (0x3B low bits); next frame_start no earlier than 48+1 cycles after axiov falls.
3. N=4; single byte A5 with last -> frame_len=46; 92 valid cycles; first nibbles A, 5, then 0.
4. 1501 bytes offered with no in_last -> 1500 accepted; frame_len=1500; in_ready low until the GAP state ends; byte 1501 is accepted as the first byte of the next frame.
5. rst asserted at cycle 50 of STREAM -> next cycle axiov=0, busy=0, in_ready=1; a fresh 4-byte frame afterwards streams correctly.
6. payload_req held high before frame_start and in_valid toggled during STREAM -> stream begins only after WAIT_REQ samples payload_req; no in_valid byte is accepted while busy=1.
